// File: rtl/l1_bus_arb.sv
// l1_bus_arb: per-hart arbiter between the L1 instruction/data caches and a
// single L2 line bus. Write-throughs from dmem are queued in a small circular
// buffer that always drains ahead of any line fill, so a fill never returns a
// line older than a write already issued by the hart. Only one L2 transaction
// is ever outstanding; fill data returns with a one-cycle data-valid pulse.
module l1_bus_arb #(
    parameter int LINE_W   = 256,
    parameter int OFFS_W   = 5,
    parameter int WB_DEPTH = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [63:0]       i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [63:0]       d_addr,
    input  logic              d_rd,
    input  logic [LINE_W-1:0] d_data_in,
    input  logic              d_wr,
    output logic [LINE_W-1:0] d_data,
    output logic              d_dv,
    output logic              d_wb_full,
    output logic              wb_ovf,
    output logic [63:0]       l2_addr,
    output logic              l2_rd,
    output logic              l2_wr,
    output logic [LINE_W-1:0] l2_data_out,
    input  logic [LINE_W-1:0] l2_data_in,
    input  logic              l2_ack
);

    localparam int          PTR_W     = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int          CNT_W     = $clog2(WB_DEPTH + 1);
    localparam logic [63:0] LINE_MASK = ~((64'd1 << OFFS_W) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD_D   = 3'd2,
        ST_RD_I   = 3'd3,
        ST_RESP_D = 3'd4,
        ST_RESP_I = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Write buffer storage; addresses are stored already line-aligned.
    logic [63:0]       r_wb_addr [WB_DEPTH];
    logic [LINE_W-1:0] r_wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_full;
    logic              r_ovf;

    // Set when dmem won the last read grant, so imem wins the next tie.
    logic              r_tie_to_i;

    logic [63:0]       r_l2_addr;
    logic              r_l2_rd;
    logic              r_l2_wr;
    logic [LINE_W-1:0] r_l2_data_out;
    logic [LINE_W-1:0] r_d_data;
    logic [LINE_W-1:0] r_i_data;
    logic              r_d_dv;
    logic              r_i_dv;

    logic              w_empty;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic              w_grant_wr;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_fill_d;
    logic              w_fill_i;

    // Advance a buffer pointer, wrapping modulo WB_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(WB_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign w_empty  = (r_count == CNT_W'(0));
    assign w_pop    = w_grant_wr ? 1'b0 : ((r_state == ST_WR) && l2_ack);
    assign w_accept = d_wr && (!r_full || w_pop);
    assign w_drop   = d_wr && r_full && !w_pop;

    // Arbitration and transaction sequencing; ack is only honoured while a strobe is up.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_fill_d    = 1'b0;
        w_fill_i    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_grant_wr  = 1'b1;
                    w_state_nxt = ST_WR;
                end else if (d_rd && (!i_rd || !r_tie_to_i)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_RD_D;
                end else if (i_rd) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_RD_I;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (l2_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD_D: begin
                if (l2_ack) begin
                    w_fill_d    = 1'b1;
                    w_state_nxt = ST_RESP_D;
                end else begin
                    w_state_nxt = ST_RD_D;
                end
            end
            ST_RD_I: begin
                if (l2_ack) begin
                    w_fill_i    = 1'b1;
                    w_state_nxt = ST_RESP_I;
                end else begin
                    w_state_nxt = ST_RD_I;
                end
            end
            // The dv cycle never re-grants: the L1 drops its request on the following hit.
            ST_RESP_D: w_state_nxt = ST_IDLE;
            ST_RESP_I: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next occupancy of the write buffer; push and pop together leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write buffer: circular FIFO with sticky overflow flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                r_wb_addr[k] <= 64'd0;
                r_wb_data[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wb_addr[r_wr_ptr] <= d_addr & LINE_MASK;
                r_wb_data[r_wr_ptr] <= d_data_in;
                r_wr_ptr            <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(WB_DEPTH));
        end
    end

    // L2 request/address/data registers, fill capture and data-valid pulses.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_l2_addr     <= 64'd0;
            r_l2_rd       <= 1'b0;
            r_l2_wr       <= 1'b0;
            r_l2_data_out <= '0;
            r_d_data      <= '0;
            r_i_data      <= '0;
            r_d_dv        <= 1'b0;
            r_i_dv        <= 1'b0;
            r_tie_to_i    <= 1'b0;
        end else begin
            r_l2_rd <= (w_state_nxt == ST_RD_D) || (w_state_nxt == ST_RD_I);
            r_l2_wr <= (w_state_nxt == ST_WR);
            r_d_dv  <= w_fill_d;
            r_i_dv  <= w_fill_i;
            if (w_grant_wr) begin
                r_l2_addr     <= r_wb_addr[r_rd_ptr];
                r_l2_data_out <= r_wb_data[r_rd_ptr];
            end else if (w_grant_d) begin
                r_l2_addr  <= d_addr & LINE_MASK;
                r_tie_to_i <= 1'b1;
            end else if (w_grant_i) begin
                r_l2_addr  <= i_addr & LINE_MASK;
                r_tie_to_i <= 1'b0;
            end
            if (w_fill_d) begin
                r_d_data <= l2_data_in;
            end
            if (w_fill_i) begin
                r_i_data <= l2_data_in;
            end
        end
    end

    assign l2_addr     = r_l2_addr;
    assign l2_rd       = r_l2_rd;
    assign l2_wr       = r_l2_wr;
    assign l2_data_out = r_l2_data_out;
    assign d_data      = r_d_data;
    assign i_data      = r_i_data;
    assign d_dv        = r_d_dv;
    assign i_dv        = r_i_dv;
    assign d_wb_full   = r_full;
    assign wb_ovf      = r_ovf;

endmodule

// File: tb/tb_l1_bus_arb.sv
// Testbench for l1_bus_arb: a directed cycle table, a hand-written reset
// sequence, then random stimulus against a transaction-level reference model.
module tb_l1_bus_arb;

    localparam int LINE_W   = 256;
    localparam int OFFS_W   = 5;
    localparam int WB_DEPTH = 2;
    localparam logic [63:0] MASK = ~((64'd1 << OFFS_W) - 64'd1);

    logic              clk;
    logic              clr_n;
    logic [63:0]       i_addr;
    logic              i_rd;
    logic [LINE_W-1:0] i_data;
    logic              i_dv;
    logic [63:0]       d_addr;
    logic              d_rd;
    logic [LINE_W-1:0] d_data_in;
    logic              d_wr;
    logic [LINE_W-1:0] d_data;
    logic              d_dv;
    logic              d_wb_full;
    logic              wb_ovf;
    logic [63:0]       l2_addr;
    logic              l2_rd;
    logic              l2_wr;
    logic [LINE_W-1:0] l2_data_out;
    logic [LINE_W-1:0] l2_data_in;
    logic              l2_ack;

    int n_vec = 0;
    int n_err = 0;

    l1_bus_arb #(.LINE_W(LINE_W), .OFFS_W(OFFS_W), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .clr_n(clr_n),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_data_in(d_data_in), .d_wr(d_wr),
        .d_data(d_data), .d_dv(d_dv), .d_wb_full(d_wb_full), .wb_ovf(wb_ovf),
        .l2_addr(l2_addr), .l2_rd(l2_rd), .l2_wr(l2_wr),
        .l2_data_out(l2_data_out), .l2_data_in(l2_data_in), .l2_ack(l2_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [255:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic rd_d, rd_i, wr, ack;
        logic [63:0] da, ia;
        logic [7:0]  dat;
        logic e_rd, e_wr;
        logic [63:0] e_addr;
        logic e_ddv, e_idv, e_full, e_ovf;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rd_d, rd_i, wr, ack, input logic [63:0] da, ia,
                                input logic [7:0] dat, input logic e_rd, e_wr,
                                input logic [63:0] e_addr, input logic e_ddv, e_idv, e_full, e_ovf,
                                input logic [7:0] e_dat);
        vec_t v;
        v.rd_d = rd_d; v.rd_i = rd_i; v.wr = wr; v.ack = ack; v.da = da; v.ia = ia; v.dat = dat;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_ddv = e_ddv; v.e_idv = e_idv;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_dat = e_dat;
        return v;
    endfunction

    task automatic do_reset();
        clr_n = 1'b0;
        #2;
        clr_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [63:0] a; logic [255:0] d; } wb_t;
    wb_t          m_q[$];
    int           m_cur;     // 0 none, 1 write, 2 dmem read, 3 imem read outstanding
    int           m_resp;    // 0 none, 1 dmem dv cycle, 2 imem dv cycle
    bit           m_next_tie_i;
    logic [63:0]  m_addr;
    logic [255:0] m_wdata, m_dd, m_id;
    bit           m_ovf;

    function automatic void model_reset();
        m_q.delete();
        m_cur = 0; m_resp = 0; m_next_tie_i = 1'b0; m_ovf = 1'b0;
        m_addr = '0; m_wdata = '0; m_dd = '0; m_id = '0;
    endfunction

    function automatic void model_edge();
        bit pop = 1'b0;
        if (m_resp != 0) begin
            m_resp = 0;
        end else if (m_cur == 1) begin
            if (l2_ack) begin pop = 1'b1; m_cur = 0; end
        end else if (m_cur == 2) begin
            if (l2_ack) begin m_dd = l2_data_in; m_resp = 1; m_cur = 0; end
        end else if (m_cur == 3) begin
            if (l2_ack) begin m_id = l2_data_in; m_resp = 2; m_cur = 0; end
        end else begin
            if (m_q.size() > 0) begin
                m_cur = 1; m_addr = m_q[0].a; m_wdata = m_q[0].d;
            end else if (d_rd && (!i_rd || !m_next_tie_i)) begin
                m_cur = 2; m_addr = d_addr & MASK; m_next_tie_i = 1'b1;
            end else if (i_rd) begin
                m_cur = 3; m_addr = i_addr & MASK; m_next_tie_i = 1'b0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (d_wr) begin
            if (m_q.size() < WB_DEPTH) m_q.push_back('{a: d_addr & MASK, d: d_data_in});
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic compare_model();
        chk("rnd_l2_rd", l2_rd, (m_cur == 2) || (m_cur == 3));
        chk("rnd_l2_wr", l2_wr, m_cur == 1);
        chk("rnd_l2_addr", l2_addr, m_addr);
        chk("rnd_l2_data_out", l2_data_out, m_wdata);
        chk("rnd_d_dv", d_dv, m_resp == 1);
        chk("rnd_i_dv", i_dv, m_resp == 2);
        chk("rnd_d_data", d_data, m_dd);
        chk("rnd_i_data", i_data, m_id);
        chk("rnd_full", d_wb_full, m_q.size() == WB_DEPTH);
        chk("rnd_ovf", wb_ovf, m_ovf);
    endtask

    initial begin
        clr_n = 1'b1; i_addr = '0; i_rd = 1'b0; d_addr = '0; d_rd = 1'b0;
        d_data_in = '0; d_wr = 1'b0; l2_data_in = '0; l2_ack = 1'b0;

        // ---- reset state ----
        #1;
        clr_n = 1'b0;
        #2;
        chk("rst_l2_rd", l2_rd, 1'b0);
        chk("rst_l2_wr", l2_wr, 1'b0);
        chk("rst_l2_addr", l2_addr, 64'd0);
        chk("rst_l2_data_out", l2_data_out, '0);
        chk("rst_d_dv", d_dv, 1'b0);
        chk("rst_i_dv", i_dv, 1'b0);
        chk("rst_d_data", d_data, '0);
        chk("rst_i_data", i_data, '0);
        chk("rst_full", d_wb_full, 1'b0);
        chk("rst_ovf", wb_ovf, 1'b0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        // ---- table: rd_d rd_i wr ack da ia dat | e_rd e_wr e_addr e_ddv e_idv e_full e_ovf e_dat ----
        // tie alternation from reset: dmem, imem, dmem, then imem alone
        tbl.push_back(mk(1,1,0,0,64'h5000,64'h6010,8'h00, 1,0,64'h5000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,0,64'h5000,64'h6010,8'h00, 1,0,64'h5000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,1,64'h5000,64'h6010,8'h81, 0,0,64'h5000,1,0,0,0,8'h81));
        tbl.push_back(mk(1,1,0,0,64'h5040,64'h6010,8'h00, 0,0,64'h5000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,0,64'h5040,64'h6010,8'h00, 1,0,64'h6000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,0,64'h5040,64'h6010,8'h00, 1,0,64'h6000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,1,64'h5040,64'h6010,8'h82, 0,0,64'h6000,0,1,0,0,8'h82));
        tbl.push_back(mk(1,1,0,0,64'h5040,64'h6050,8'h00, 0,0,64'h6000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,0,64'h5040,64'h6050,8'h00, 1,0,64'h5040,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,0,64'h5040,64'h6050,8'h00, 1,0,64'h5040,0,0,0,0,8'h00));
        tbl.push_back(mk(1,1,0,1,64'h5040,64'h6050,8'h83, 0,0,64'h5040,1,0,0,0,8'h83));
        tbl.push_back(mk(0,1,0,0,64'h5040,64'h6050,8'h00, 0,0,64'h5040,0,0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,0,64'h5040,64'h6050,8'h00, 1,0,64'h6040,0,0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,1,64'h5040,64'h6050,8'h84, 0,0,64'h6040,0,1,0,0,8'h84));
        tbl.push_back(mk(0,0,0,0,64'h5040,64'h6050,8'h00, 0,0,64'h6040,0,0,0,0,8'h00));
        // dmem fill at 0x1234, ack three cycles after the strobe; stray ack ignored
        tbl.push_back(mk(1,0,0,0,64'h1234,64'h0,8'h00, 1,0,64'h1220,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,0,64'h1234,64'h0,8'h00, 1,0,64'h1220,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,0,64'h1234,64'h0,8'h00, 1,0,64'h1220,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,1,64'h1234,64'h0,8'hA5, 0,0,64'h1220,1,0,0,0,8'hA5));
        tbl.push_back(mk(1,0,0,0,64'h1234,64'h0,8'h00, 0,0,64'h1220,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,1,64'h1234,64'h0,8'hFF, 0,0,64'h1220,0,0,0,0,8'h00));
        // write-through then read of the same line: write drains first
        tbl.push_back(mk(0,0,1,0,64'h2000,64'h0,8'h3C, 0,0,64'h1220,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,0,64'h2000,64'h0,8'h00, 0,1,64'h2000,0,0,0,0,8'h3C));
        tbl.push_back(mk(1,0,0,1,64'h2000,64'h0,8'h00, 0,0,64'h2000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,0,64'h2000,64'h0,8'h00, 1,0,64'h2000,0,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,1,64'h2000,64'h0,8'h77, 0,0,64'h2000,1,0,0,0,8'h77));
        tbl.push_back(mk(1,0,0,0,64'h2000,64'h0,8'h00, 0,0,64'h2000,0,0,0,0,8'h00));
        // full buffer, pop and push in the same cycle: accepted, no overflow
        tbl.push_back(mk(0,0,1,0,64'h4000,64'h0,8'h44, 0,0,64'h2000,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,1,0,64'h4040,64'h0,8'h55, 0,1,64'h4000,0,0,1,0,8'h44));
        tbl.push_back(mk(0,0,1,1,64'h4080,64'h0,8'h66, 0,0,64'h4000,0,0,1,0,8'h00));
        tbl.push_back(mk(0,0,0,0,64'h4080,64'h0,8'h00, 0,1,64'h4040,0,0,1,0,8'h55));
        tbl.push_back(mk(0,0,0,1,64'h4080,64'h0,8'h00, 0,0,64'h4040,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,0,64'h4080,64'h0,8'h00, 0,1,64'h4080,0,0,0,0,8'h66));
        tbl.push_back(mk(0,0,0,1,64'h4080,64'h0,8'h00, 0,0,64'h4080,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,0,0,64'h4080,64'h0,8'h00, 0,0,64'h4080,0,0,0,0,8'h00));
        // three writes with ack low: third dropped, overflow sticky, two writes follow
        tbl.push_back(mk(0,0,1,0,64'h3000,64'h0,8'h11, 0,0,64'h4080,0,0,0,0,8'h00));
        tbl.push_back(mk(0,0,1,0,64'h3040,64'h0,8'h22, 0,1,64'h3000,0,0,1,0,8'h11));
        tbl.push_back(mk(0,0,1,0,64'h3080,64'h0,8'h33, 0,1,64'h3000,0,0,1,1,8'h11));
        tbl.push_back(mk(0,0,0,1,64'h3080,64'h0,8'h00, 0,0,64'h3000,0,0,0,1,8'h00));
        tbl.push_back(mk(0,0,0,0,64'h3080,64'h0,8'h00, 0,1,64'h3040,0,0,0,1,8'h22));
        tbl.push_back(mk(0,0,0,1,64'h3080,64'h0,8'h00, 0,0,64'h3040,0,0,0,1,8'h00));
        tbl.push_back(mk(0,0,0,0,64'h3080,64'h0,8'h00, 0,0,64'h3040,0,0,0,1,8'h00));

        foreach (tbl[k]) begin
            d_rd = tbl[k].rd_d; i_rd = tbl[k].rd_i; d_wr = tbl[k].wr; l2_ack = tbl[k].ack;
            d_addr = tbl[k].da; i_addr = tbl[k].ia;
            d_data_in = rep(tbl[k].dat); l2_data_in = rep(tbl[k].dat);
            @(posedge clk);
            #1;
            chk("tbl_l2_rd", l2_rd, tbl[k].e_rd);
            chk("tbl_l2_wr", l2_wr, tbl[k].e_wr);
            chk("tbl_l2_addr", l2_addr, tbl[k].e_addr);
            chk("tbl_d_dv", d_dv, tbl[k].e_ddv);
            chk("tbl_i_dv", i_dv, tbl[k].e_idv);
            chk("tbl_full", d_wb_full, tbl[k].e_full);
            chk("tbl_ovf", wb_ovf, tbl[k].e_ovf);
            if (tbl[k].e_ddv) chk("tbl_d_data", d_data, rep(tbl[k].e_dat));
            if (tbl[k].e_idv) chk("tbl_i_data", i_data, rep(tbl[k].e_dat));
            if (tbl[k].e_wr)  chk("tbl_l2_data_out", l2_data_out, rep(tbl[k].e_dat));
        end
        d_rd = 1'b0; i_rd = 1'b0; d_wr = 1'b0; l2_ack = 1'b0;

        // ---- async reset while a dmem read is outstanding ----
        do_reset();
        d_rd = 1'b1; d_addr = 64'h7008;
        @(posedge clk); #1;
        chk("hs_rd_issued", l2_rd, 1'b1);
        chk("hs_rd_addr", l2_addr, 64'h7000);
        d_wr = 1'b1; d_data_in = rep(8'h5A);
        repeat (3) begin @(posedge clk); #1; end
        d_wr = 1'b0;
        chk("hs_full", d_wb_full, 1'b1);
        chk("hs_ovf", wb_ovf, 1'b1);
        chk("hs_still_rd", l2_rd, 1'b1);
        #1;
        clr_n = 1'b0;
        #1;
        chk("hs_rst_l2_rd", l2_rd, 1'b0);
        chk("hs_rst_d_dv", d_dv, 1'b0);
        chk("hs_rst_full", d_wb_full, 1'b0);
        chk("hs_rst_ovf", wb_ovf, 1'b0);
        chk("hs_rst_addr", l2_addr, 64'd0);
        clr_n = 1'b1;
        @(posedge clk); #1;
        chk("hs_regrant_rd", l2_rd, 1'b1);
        chk("hs_regrant_wr", l2_wr, 1'b0);
        chk("hs_regrant_addr", l2_addr, 64'h7000);
        l2_ack = 1'b1; l2_data_in = rep(8'hC3);
        @(posedge clk); #1;
        l2_ack = 1'b0;
        chk("hs_dv", d_dv, 1'b1);
        chk("hs_data", d_data, rep(8'hC3));
        d_rd = 1'b0;
        @(posedge clk); #1;
        chk("hs_dv_one_cycle", d_dv, 1'b0);

        // ---- random stimulus against the reference model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
                model_reset();
            end
            if (!d_rd) begin
                d_addr = {$urandom(), $urandom()};
                if ($urandom_range(0, 5) == 0) d_rd = 1'b1;
            end
            if (!i_rd && $urandom_range(0, 5) == 0) begin
                i_rd = 1'b1;
                i_addr = {$urandom(), $urandom()};
            end
            d_wr = ((n / 500) % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
            d_data_in  = {8{$urandom()}};
            l2_data_in = {8{$urandom()}};
            l2_ack     = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_edge();
            #1;
            compare_model();
            if (m_resp == 1) d_rd = 1'b0;
            if (m_resp == 2) i_rd = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
